// File: rtl/div_32_bit_seq.sv
// ---------------------------------------------------------------------------
// div_32_bit_seq
//
// Multi-cycle restoring divider for the MIPS DIV/DIVU path. Produces the
// quotient (for LO) and the remainder (for HI) after a fixed latency that does
// not depend on the operands. The ALU stalls on busy. Each RUN cycle makes one
// trial subtraction of the divisor magnitude from the shifted partial
// remainder; the borrow of that subtraction selects the quotient bit.
//
// Sequence: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> DONE (1 cycle).
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous, active-low reset
//   start        in   1      launches a division; only looked at in IDLE
//   is_signed    in   1      1 = DIV (signed), 0 = DIVU; sampled with start
//   dividend     in   WIDTH  sampled with start
//   divisor      in   WIDTH  sampled with start
//   busy         out  1      high from the cycle after start through done
//   done         out  1      one-cycle pulse; results valid from here on
//   quotient     out  WIDTH  LO result, held until the next accepted start
//   remainder    out  WIDTH  HI result, held until the next accepted start
//   div_by_zero  out  1      last operation had a zero divisor
//
// Configuration macro
//   SIGNED_DIV_EN  defined:   is_signed is honoured (magnitude conversion on
//                             entry, sign fix-up in FIX).
//                  undefined: every operation is unsigned; is_signed is
//                             ignored. FIX is still one cycle so the latency
//                             is identical in both builds.
// ---------------------------------------------------------------------------
module div_32_bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;

    // rem_q is the partial remainder; quo_q starts as the dividend magnitude
    // and is shifted left each iteration, so its MSB is always the next
    // dividend bit and its LSBs fill up with quotient bits.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    // Raw dividend is kept for the divide-by-zero remainder, which must be the
    // operand exactly as supplied (not its magnitude).
    logic [WIDTH-1:0] dividend_q, dividend_d;

    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

`ifdef SIGNED_DIV_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             sign_a;
    logic             sign_b;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction
`else
    logic             unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    // Trial subtraction: the shifted remainder is WIDTH+1 bits wide, the
    // difference is computed one bit wider so its top bit is the borrow.
    logic [WIDTH:0]   shifted;
    logic             trial_borrow;
    logic             unused_trial_top;
    logic [WIDTH-1:0] trial_diff;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            dividend_q    <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            dividend_q    <= dividend_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
`ifdef SIGNED_DIV_EN
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
`endif
        end
    end

    // Next-state and datapath logic. Everything holds by default; the visible
    // results are only written in FIX so they stay stable through RUN.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        dividend_d    = dividend_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        sign_a        = is_signed & dividend[WIDTH-1];
        sign_b        = is_signed & divisor[WIDTH-1];
`endif

        shifted = {rem_q, quo_q[WIDTH-1]};
        {trial_borrow, unused_trial_top, trial_diff} =
            {1'b0, shifted} - {2'b00, dvs_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    rem_d      = '0;
                    count_d    = '0;
`ifdef SIGNED_DIV_EN
                    quo_d      = sign_a ? negate(dividend) : dividend;
                    dvs_d      = sign_b ? negate(divisor) : divisor;
                    neg_quo_d  = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
`else
                    quo_d      = dividend;
                    dvs_d      = divisor;
`endif
                    state_d    = ST_RUN;
                end
            end

            ST_RUN: begin
                // On borrow the unmodified shifted value is restored; its top
                // bit is necessarily 0 in that case since dvs_q < 2^WIDTH.
                rem_d   = trial_borrow ? shifted[WIDTH-1:0] : trial_diff;
                quo_d   = {quo_q[WIDTH-2:0], ~trial_borrow};
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                // A zero divisor already yields all-ones from the iteration,
                // but the remainder would be the magnitude, so both are
                // forced to keep the result independent of the sign logic.
                if (dvs_q == '0) begin
                    quotient_d    = '1;
                    remainder_d   = dividend_q;
                    div_by_zero_d = 1'b1;
                end else begin
`ifdef SIGNED_DIV_EN
                    quotient_d    = neg_quo_q ? negate(quo_q) : quo_q;
                    remainder_d   = neg_rem_q ? negate(rem_q) : rem_q;
`else
                    quotient_d    = quo_q;
                    remainder_d   = rem_q;
`endif
                    div_by_zero_d = 1'b0;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_32_bit_seq.sv
// ---------------------------------------------------------------------------
// tb_div_32_bit_seq
//
// Self-checking bench for div_32_bit_seq. A behavioural model predicts busy,
// done and the held results from the division rules and the fixed latency;
// a compare loop checks the DUT against it every falling edge. Directed
// vectors with literal expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_div_32_bit_seq;

`ifdef SIGNED_DIV_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    localparam int LATENCY = 34;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail = 0;

    div_32_bit_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference result: {div_by_zero, quotient, remainder}, from plain
    // integer division (truncating toward zero for the signed case).
    function automatic logic [64:0] modelDiv(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (s && SIGNED_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {1'b0, q[31:0], r[31:0]};
        end
        return {1'b0, a / b, a % b};
    endfunction

    // Model: an operation occupies LATENCY cycles from acceptance; the last
    // of those is the done cycle, when the new results appear.
    int          mRemaining;
    logic [31:0] mA;
    logic [31:0] mB;
    logic        mS;
    logic [31:0] mQ;
    logic [31:0] mR;
    logic        mZ;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRemaining <= 0;
            mQ         <= '0;
            mR         <= '0;
            mZ         <= 1'b0;
        end else if (mRemaining > 0) begin
            mRemaining <= mRemaining - 1;
            if (mRemaining == 2) {mZ, mQ, mR} <= modelDiv(mA, mB, mS);
        end else if (start) begin
            mRemaining <= LATENCY;
            mA         <= dividend;
            mB         <= divisor;
            mS         <= is_signed;
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] q,
                               input logic [31:0] r, input logic z);
        checkVal({name, " quotient"}, quotient, q);
        checkVal({name, " remainder"}, remainder, r);
        checkVal({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, z});
    endtask

    // Issue one start pulse and wait (bounded) for done; lat counts clock
    // edges from the sampling edge to the first cycle with done high.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic s, output int lat);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runCase(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic s,
                           input logic [31:0] q, input logic [31:0] r,
                           input logic z);
        int lat;
        applyStimulus(a, b, s, lat);
        checkVal({name, " latency"}, lat, LATENCY);
        checkOutput(name, q, r, z);
    endtask

    initial begin
        int lat;
        int k;

        fork
            forever begin
                @(negedge clk);
                checkVal("cycle busy", {31'd0, busy}, {31'd0, mRemaining > 0});
                checkVal("cycle done", {31'd0, done}, {31'd0, mRemaining == 1});
                checkVal("cycle quotient", quotient, mQ);
                checkVal("cycle remainder", remainder, mR);
                checkVal("cycle div_by_zero", {31'd0, div_by_zero}, {31'd0, mZ});
            end
        join_none

        repeat (3) @(negedge clk);
        checkVal("reset busy", {31'd0, busy}, 32'd0);
        checkVal("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset", 32'd0, 32'd0, 1'b0);
        rst_n = 1'b1;

        $display("[TB] unsigned vectors");
        runCase("7/6", 32'd7, 32'd6, 1'b0, 32'd1, 32'd1, 1'b0);
        runCase("0x80/0x40", 32'h80, 32'h40, 1'b0, 32'd2, 32'd0, 1'b0);
        runCase("6/7", 32'd6, 32'd7, 1'b0, 32'd0, 32'd6, 1'b0);
        runCase("100/3", 32'd100, 32'd3, 1'b0, 32'd33, 32'd1, 1'b0);
        runCase("max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        runCase("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0);
        runCase("u -7/6", 32'hFFFF_FFF9, 32'd6, 1'b0, 32'h2AAA_AAA9, 32'd3, 1'b0);
        runCase("0x20/0", 32'h20, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h20, 1'b0 | 1'b1);
        runCase("after dbz", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0);

`ifdef SIGNED_DIV_EN
        $display("[TB] signed vectors");
        runCase("s -7/6", 32'hFFFF_FFF9, 32'd6, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runCase("s 7/-6", 32'd7, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        runCase("s -7/-6", 32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 32'd1, 32'hFFFF_FFFF, 1'b0);
        runCase("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        runCase("s -32/0", 32'hFFFF_FFE0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 1'b1);
`else
        $display("[TB] is_signed ignored in unsigned build");
        runCase("is_signed -7/6", 32'hFFFF_FFF9, 32'd6, 1'b1, 32'h2AAA_AAA9, 32'd3, 1'b0);
`endif

        $display("[TB] start while busy and in done cycle");
        @(negedge clk);
        dividend  = 32'd7;
        divisor   = 32'd6;
        is_signed = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkVal("busy-ignore done seen", {31'd0, done}, 32'd1);
        dividend = 32'd55;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal("done-cycle start ignored", {31'd0, busy}, 32'd0);
        checkOutput("held 7/6", 32'd1, 32'd1, 1'b0);
        repeat (3) @(negedge clk);
        checkVal("still idle", {31'd0, busy}, 32'd0);
        runCase("55/5", 32'd55, 32'd5, 1'b0, 32'd11, 32'd0, 1'b0);

        $display("[TB] reset mid-run");
        @(negedge clk);
        dividend = 32'd123456;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("abort busy", {31'd0, busy}, 32'd0);
        checkVal("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort", 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) k++;
        end
        checkVal("no done after abort", k, 0);
        runCase("post-reset 123456/7", 32'd123456, 32'd7, 1'b0, 32'd17636, 32'd4, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
